npp_ingress_buffer: RTL
=======================

# npp_ingress_buffer

Parametrised NPP-to-NoC ingress stage. Accepts NPP flits under a valid/ready handshake and enforces head/tail packet framing, dropping orphan flits and flagging truncated packets. Buffers legal flits in a synchronous FIFO and presents them to the NoC master path in the packed `{valid, data}` format with side-band head/tail. It sits between the NPP source and the noc2axi conversion logic and adds backpressure, buffering and error reporting to the plain pass-through stage.

## Interface
- `DATA_WIDTH`, 128: NPP payload width in bits.
- `FIFO_DEPTH`, 8: flit buffer entries; power of two, ≥2.
- `CNT_WIDTH`, 16: width of the statistics counters.

- `clk` input 1: single clock; all logic is rising-edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `npp_valid` input 1: NPP flit valid.
- `npp_ready` output 1: ingress can accept a flit.
- `npp_data` input DATA_WIDTH: NPP payload.
- `npp_head` input 1: first flit of a packet.
- `npp_tail` input 1: last flit of a packet; head and tail both set means a single-flit packet.
- `noc_data` output DATA_WIDTH+1: `{valid, data}`; bit DATA_WIDTH is output valid.
- `head` output 1: head flag of the output flit.
- `tail` output 1: tail flag of the output flit.
- `noc_ready` input 1: downstream accepts the output flit.
- `err_orphan` output 1: one-cycle pulse when a non-head flit is dropped outside a packet.
- `err_trunc` output 1: one-cycle pulse when a head flit arrives inside an open packet.
- `fifo_level` output $clog2(FIFO_DEPTH)+1: current occupancy.
- `pkt_cnt` output CNT_WIDTH: count of tail flits written.
- `err_cnt` output CNT_WIDTH: count of err_orphan and err_trunc events.

## Operation
- Input transfer: `npp_valid && npp_ready` at a rising edge.
- `npp_ready = !full`. A write is never accepted when the FIFO is full, even if a pop happens in the same cycle.
- Output transfer (pop): `noc_data[DATA_WIDTH] && noc_ready`.
- The output is first-word-fall-through. When the FIFO is empty, `noc_data`, `head` and `tail` are all 0.
- The framing FSM has two states, IDLE and IN_PKT. Its transitions apply to accepted flits only.
  - IDLE, head=1, tail=1: write the flit; stay in IDLE.
  - IDLE, head=1, tail=0: write the flit; go to IN_PKT.
  - IDLE, head=0: do not write the flit; it is still handshaken (consumed). Pulse `err_orphan`; stay in IDLE.
  - IN_PKT, head=0: write the flit; go to IDLE if tail=1.
  - IN_PKT, head=1: write the flit and pulse `err_trunc`. The next state follows that flit's tail bit: IDLE if tail=1, IN_PKT otherwise.
- A dropped orphan flit never occupies a FIFO entry.
- `fifo_level` counts writes minus pops. A simultaneous write and pop leaves it unchanged.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Full and empty are derived from `fifo_level`.

## Timing
- Reset (`rst_n` = 0 at an edge) clears:
  - FIFO pointers, so level is 0;
  - the FSM, to IDLE;
  - `noc_data`, `head`, `tail`, `err_orphan`, `err_trunc`, `pkt_cnt`, `err_cnt`, all to 0.
- `npp_ready` is 0 while `rst_n` is 0.
- Reset mid-packet discards all buffered and partial flits. No tail is synthesised.
- Write-to-output latency is 1 cycle: a flit accepted at edge N is visible on `noc_data` after edge N, when the FIFO was empty.
- Error pulses assert in the cycle after the offending edge and last exactly 1 cycle.
- Counters update one cycle after the event, registered.
- `npp_ready` deasserts the cycle after the write that fills the FIFO. It reasserts the cycle after the first pop.

## Configuration
- `NPP_IN_STATS_EN` defined: `pkt_cnt` and `err_cnt` are implemented.
  - Both are saturating at 2^CNT_WIDTH−1.
  - A simultaneous err_orphan and err_trunc is impossible, so err_cnt increments by at most 1 per cycle.
- Not defined: the ports remain and are tied to 0; no counter flops are built.

## Structure
- Package `npp_pkg` holds:
  - the FSM state enum `npp_frm_state_t` (IDLE, IN_PKT);
  - the flit struct `npp_flit_t` {head, tail, data};
  - a localparam for the flit width DATA_WIDTH+2.
- Sub-module `npp_sync_fifo`: a generic FWFT synchronous FIFO, parametrised by width and depth, with level output.
- Framing FSM, error pulses and counters live in the top.

## Test plan
- **Single-flit packet:** reset, then drive head=1, tail=1, data=0x1234 with noc_ready=1.
  - Next cycle: `noc_data` = {1, 0x1234}, head=1, tail=1.
  - Following cycle: empty.
  - `pkt_cnt` = 1.
- **Fill and backpressure:** send a 10-flit packet with noc_ready=0 and FIFO_DEPTH=8.
  - `npp_ready` drops after the 8th accept; `fifo_level` = 8.
  - Raise noc_ready: all 10 flits emerge in order, head on the first and tail on the last.
- **Orphan:** in IDLE, send head=0, tail=0, data=0xBAD.
  - `err_orphan` pulses for 1 cycle and `err_cnt` = 1.
  - `fifo_level` stays 0 and the output stays empty.
- **Truncation:** send head, body, then head+tail.
  - `err_trunc` pulses once; all 3 flits are output; the FSM ends in IDLE.
- **Simultaneous push/pop at full:** with level=8 and noc_ready=1, hold npp_valid=1.
  - The first cycle pops only, giving level=7.
  - Then sustained push+pop keeps level at 7 with 1 flit per cycle.
- **Reset mid-packet:** after head+2 body flits are buffered, assert rst_n=0 for 1 cycle.
  - Outputs and counters read 0 and `fifo_level` = 0.
  - A following body flit is counted as an orphan.

Source files
------------

// File: rtl/npp_pkg.sv
// -----------------------------------------------------------------------------
// npp_pkg
// Shared types and constants for the NPP ingress buffer.
//   npp_frm_state_t : packet framing state (IDLE, IN_PKT)
//   npp_flit_t      : buffered flit layout {head, tail, data} at the default
//                     payload width; the top packs flits in the same order at
//                     its own DATA_WIDTH.
//   NPP_FLIT_META_W : number of side-band bits stored with each payload.
//   NPP_FLIT_WIDTH  : flit width at the default payload width (DATA_WIDTH+2).
// -----------------------------------------------------------------------------
package npp_pkg;

   localparam int unsigned NPP_DATA_WIDTH  = 128;
   localparam int unsigned NPP_FLIT_META_W = 2;
   localparam int unsigned NPP_FLIT_WIDTH  = NPP_DATA_WIDTH + NPP_FLIT_META_W;

   typedef enum logic {
      IDLE   = 1'b0,
      IN_PKT = 1'b1
   } npp_frm_state_t;

   typedef struct packed {
      logic                      head;
      logic                      tail;
      logic [NPP_DATA_WIDTH-1:0] data;
   } npp_flit_t;

endpackage

// File: rtl/npp_sync_fifo.sv
// -----------------------------------------------------------------------------
// npp_sync_fifo
// Generic first-word-fall-through synchronous FIFO with occupancy output.
// Parameters:
//   WIDTH : entry width in bits
//   DEPTH : number of entries, power of two, >= 2
// Ports:
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset (clears pointers and level)
//   wr_en_i   : push request, ignored while full
//   wr_data_i : push data
//   rd_en_i   : pop request, ignored while empty
//   rd_data_o : head entry, forced to zero while empty
//   level_o   : current occupancy, 0..DEPTH
//   full_o    : level_o == DEPTH
//   empty_o   : level_o == 0
// -----------------------------------------------------------------------------
module npp_sync_fifo
   import npp_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned LVL_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic [LVL_W-1:0] level_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             push_s;
   logic             pop_s;

   // Full/empty come from the level counter, so pointers may freely wrap.
   assign full_o  = (level_q == LVL_W'(DEPTH));
   assign empty_o = (level_q == {LVL_W{1'b0}});
   assign push_s  = wr_en_i && !full_o;
   assign pop_s   = rd_en_i && !empty_o;

   // Next-state for pointers and occupancy.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   // Pointer and level registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         level_q  <= {LVL_W{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage array; contents need no reset because empty gates the output.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

   assign rd_data_o = empty_o ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];
   assign level_o   = level_q;

endmodule

// File: rtl/npp_ingress_buffer.sv
// -----------------------------------------------------------------------------
// npp_ingress_buffer
// NPP-to-NoC ingress stage: accepts NPP flits on a valid/ready handshake,
// enforces head/tail framing (orphan non-head flits outside a packet are
// consumed and dropped, a head inside an open packet is kept and flagged as
// truncation), buffers legal flits in an FWFT FIFO and presents them as
// {valid, data} with side-band head/tail.
//
// Configuration macro: NPP_IN_STATS_EN
//   defined   : pkt_cnt / err_cnt are saturating registered counters
//   undefined : pkt_cnt / err_cnt are tied to zero, no counter flops
//
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   npp_valid/npp_ready  : input handshake (ready = !full, 0 in reset)
//   npp_data/head/tail   : input payload and framing flags
//   noc_data             : {valid, data}, all zero when empty
//   head, tail           : framing flags of the presented flit
//   noc_ready            : downstream accept; pop = valid && noc_ready
//   err_orphan           : 1-cycle pulse, dropped orphan flit
//   err_trunc            : 1-cycle pulse, head seen inside open packet
//   fifo_level           : buffer occupancy
//   pkt_cnt, err_cnt     : tail-flit and error-event statistics
// -----------------------------------------------------------------------------
module npp_ingress_buffer
   import npp_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 128,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned CNT_WIDTH  = 16,
   localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  npp_valid,
   output logic                  npp_ready,
   input  logic [DATA_WIDTH-1:0] npp_data,
   input  logic                  npp_head,
   input  logic                  npp_tail,
   output logic [DATA_WIDTH:0]   noc_data,
   output logic                  head,
   output logic                  tail,
   input  logic                  noc_ready,
   output logic                  err_orphan,
   output logic                  err_trunc,
   output logic [LVL_W-1:0]      fifo_level,
   output logic [CNT_WIDTH-1:0]  pkt_cnt,
   output logic [CNT_WIDTH-1:0]  err_cnt
);

   localparam int unsigned FLIT_W = DATA_WIDTH + NPP_FLIT_META_W;

   npp_frm_state_t    state_q, state_d;
   logic              accept_s;
   logic              wr_en_s;
   logic              orphan_s;
   logic              trunc_s;
   logic              pop_s;
   logic              full_s;
   logic              empty_s;
   logic [FLIT_W-1:0] wr_flit_s;
   logic [FLIT_W-1:0] rd_flit_s;
   logic              err_orphan_q;
   logic              err_trunc_q;

   // Ready is held low during reset so nothing is consumed while clearing.
   assign npp_ready = rst_n && !full_s;
   assign accept_s  = npp_valid && npp_ready;
   assign pop_s     = !empty_s && noc_ready;
   // Same field order as npp_flit_t: {head, tail, data}.
   assign wr_flit_s = {npp_head, npp_tail, npp_data};

   // Framing FSM next state, write enable and error events for accepted flits.
   always_comb begin
      state_d  = state_q;
      wr_en_s  = 1'b0;
      orphan_s = 1'b0;
      trunc_s  = 1'b0;
      if (accept_s) begin
         case (state_q)
            IDLE: begin
               if (npp_head) begin
                  wr_en_s = 1'b1;
                  state_d = npp_tail ? IDLE : IN_PKT;
               end else begin
                  orphan_s = 1'b1;
                  state_d  = IDLE;
               end
            end
            IN_PKT: begin
               // A new head truncates the open packet but is itself kept and
               // starts the next packet.
               wr_en_s = 1'b1;
               trunc_s = npp_head;
               state_d = npp_tail ? IDLE : IN_PKT;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Framing state and registered error pulses.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         err_orphan_q <= 1'b0;
         err_trunc_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         err_orphan_q <= orphan_s;
         err_trunc_q  <= trunc_s;
      end
   end

   npp_sync_fifo #(
      .WIDTH (FLIT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en_i   (wr_en_s),
      .wr_data_i (wr_flit_s),
      .rd_en_i   (pop_s),
      .rd_data_o (rd_flit_s),
      .level_o   (fifo_level),
      .full_o    (full_s),
      .empty_o   (empty_s)
   );

   // rd_flit_s is already zero when empty, so the output is all zero then.
   assign noc_data   = {!empty_s, rd_flit_s[DATA_WIDTH-1:0]};
   assign head       = rd_flit_s[DATA_WIDTH+1];
   assign tail       = rd_flit_s[DATA_WIDTH];
   assign err_orphan = err_orphan_q;
   assign err_trunc  = err_trunc_q;

`ifdef NPP_IN_STATS_EN
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

   logic [CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
   logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
   logic                 tail_wr_s;

   // Only tails that are actually buffered count as packets.
   assign tail_wr_s = wr_en_s && npp_tail;

   // Saturating increments; orphan and truncation cannot coincide.
   always_comb begin
      pkt_cnt_d = pkt_cnt_q;
      err_cnt_d = err_cnt_q;
      if (tail_wr_s && (pkt_cnt_q != CNT_MAX)) begin
         pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
      end else begin
         pkt_cnt_d = pkt_cnt_q;
      end
      if ((orphan_s || trunc_s) && (err_cnt_q != CNT_MAX)) begin
         err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
      end else begin
         err_cnt_d = err_cnt_q;
      end
   end

   // Statistics counter registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pkt_cnt_q <= {CNT_WIDTH{1'b0}};
         err_cnt_q <= {CNT_WIDTH{1'b0}};
      end else begin
         pkt_cnt_q <= pkt_cnt_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign pkt_cnt = pkt_cnt_q;
   assign err_cnt = err_cnt_q;
`else
   assign pkt_cnt = {CNT_WIDTH{1'b0}};
   assign err_cnt = {CNT_WIDTH{1'b0}};
`endif

endmodule
